// File: rtl/icache_blocked_pkg.sv
// icache_blocked_pkg: shared word type and controller state encoding for the instruction cache
package icache_blocked_pkg;
    typedef logic [31:0] word_t;
    typedef logic [0:0] icache_state_t;
    localparam icache_state_t IDLE = 1'b0;
    localparam icache_state_t FILL = 1'b1;
endpackage

// File: rtl/icache_blocked_sat_counter.sv
// icache_blocked_sat_counter: saturating event counter.
//  CLK in, nRST in (sync active-low clear), inc in (count pulse), count out [W-1:0]
module icache_blocked_sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge CLK)
        if (!nRST) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/icache_blocked.sv
// icache_blocked: direct-mapped instruction cache with multi-word block fill.
//  CLK, nRST (sync active-low); fetch side imemREN/imemaddr -> ihit/imemload; iflush invalidates all;
//  memory side iREN/iaddr -> iwait/iload; hit_count/miss_count saturating performance counters.
module icache_blocked
    import icache_blocked_pkg::*;
#(
    parameter int NSETS       = 16,
    parameter int BLOCK_WORDS = 2,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    input  logic             iflush,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int WOFF = $clog2(BLOCK_WORDS);
    localparam int WB   = (WOFF > 0) ? WOFF : 1;
    localparam int IDXW = $clog2(NSETS);
    localparam int TAGW = 30 - WOFF - IDXW;
    icache_state_t   state;
    word_t           fill_addr;
    logic [WB-1:0]   fill_cnt, word_sel;
    logic [IDXW-1:0] idx, fill_idx;
    logic [TAGW-1:0] tag_in, fill_tag;
    logic [NSETS-1:0] valid;
    logic [TAGW-1:0] tags [NSETS];
    word_t           data [NSETS][BLOCK_WORDS];
    logic            hit, miss, fill_we, last_word;
    // Masking before the cast keeps the word select at zero when a block is a single word.
    assign word_sel  = WB'((imemaddr >> 2) & word_t'(BLOCK_WORDS - 1));
    assign idx       = IDXW'(imemaddr >> (2 + WOFF));
    assign tag_in    = TAGW'(imemaddr >> (2 + WOFF + IDXW));
    assign fill_idx  = IDXW'(fill_addr >> (2 + WOFF));
    assign fill_tag  = TAGW'(fill_addr >> (2 + WOFF + IDXW));
    assign hit       = nRST & imemREN & valid[idx] & (tags[idx] == tag_in) & (state == IDLE) & ~iflush;
    assign miss      = imemREN & ~hit & (state == IDLE) & ~iflush;
    assign last_word = fill_cnt == WB'(BLOCK_WORDS - 1);
    assign fill_we   = (state == FILL) & ~iwait;
    assign ihit      = hit;
    assign imemload  = data[idx][word_sel];
    assign iREN      = nRST & (state == FILL);
    assign iaddr     = fill_addr + (32'(fill_cnt) << 2);
    always_ff @(posedge CLK)
        if (!nRST) begin
            state    <= IDLE;
            valid    <= '0;
            fill_cnt <= '0;
        end else if (iflush) begin
            state    <= IDLE;
            valid    <= '0;
            fill_cnt <= '0;
        end else if (miss) begin
            fill_addr <= imemaddr & ~word_t'(BLOCK_WORDS * 4 - 1);
            fill_cnt  <= '0;
            state     <= FILL;
        end else if (fill_we) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (last_word) begin
                valid[fill_idx] <= 1'b1;
                state           <= IDLE;
            end
        end
    // Storage is not reset; valid bits alone decide whether contents are usable.
    always_ff @(posedge CLK)
        if (nRST && !iflush && fill_we) begin
            data[fill_idx][fill_cnt] <= iload;
            if (last_word) tags[fill_idx] <= fill_tag;
        end
    icache_blocked_sat_counter #(.W(CNT_W)) u_hit_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (hit),
        .count (hit_count)
    );
    icache_blocked_sat_counter #(.W(CNT_W)) u_miss_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (miss),
        .count (miss_count)
    );
endmodule

// File: tb/tb_icache_blocked.sv
// tb_icache_blocked: directed and random fetches checked against a set/tag reference model
module tb_icache_blocked;
    logic        CLK = 1'b0;
    logic        nRST, imemREN, iflush, iwait, ihit, iREN;
    logic [31:0] imemaddr, imemload, iaddr, iload;
    logic [3:0]  hit_count, miss_count;
    int n_assert = 0, n_fail = 0;
    int mhit, mmiss, wcnt = 0;
    bit mvalid [16];
    int mtag [16];

    icache_blocked #(.NSETS(16), .BLOCK_WORDS(2), .CNT_W(4)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
        .imemload(imemload), .iflush(iflush), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
        .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Memory: each word is busy for two cycles and delivers on the third.
    always @(posedge CLK) wcnt <= (iREN && wcnt != 2) ? wcnt + 1 : 0;
    assign iwait = !(iREN && wcnt == 2);
    assign iload = memval(iaddr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        return mvalid[(a >> 3) & 15] && mtag[(a >> 3) & 15] == int'(a >> 7);
    endfunction

    function automatic int sat(input int v);
        return v < 15 ? v + 1 : 15;
    endfunction

    task automatic model_clear();
        foreach (mvalid[i]) mvalid[i] = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] a, input bit redir, input logic [31:0] b, output bit done);
        int w;
        logic [31:0] base;
        #1;
        chk("iren_idle", {31'b0, iREN}, 0);
        if (model_hit(a)) begin
            chk("ihit", {31'b0, ihit}, 1);
            chk("imemload", imemload, memval(a));
            mhit = sat(mhit);
            done = 1'b1;
        end else begin
            chk("ihit", {31'b0, ihit}, 0);
            mmiss = sat(mmiss);
            base = a & ~32'h7;
            w = 0;
            for (int c = 1; c <= 6; c++) begin
                @(negedge CLK);
                if (c == 1 && redir) imemaddr = b;
                #1;
                chk("iren_fill", {31'b0, iREN}, 1);
                if (!iwait) begin
                    chk("iaddr", iaddr, base + 32'(4 * w));
                    w++;
                end
            end
            mvalid[(a >> 3) & 15] = 1'b1;
            mtag[(a >> 3) & 15] = int'(a >> 7);
            @(negedge CLK);
            done = 1'b0;
        end
    endtask

    task automatic fetch(input logic [31:0] a, input bit redir = 1'b0, input logic [31:0] b = 0);
        bit done;
        @(negedge CLK);
        imemaddr = a;
        imemREN = 1'b1;
        lookup(a, redir, b, done);
        for (int k = 0; k < 3 && !done; k++) lookup(imemaddr, 1'b0, 0, done);
        chk("fetch_done", {31'b0, done}, 1);
    endtask

    task automatic check_counts();
        @(negedge CLK);
        imemREN = 1'b0;
        #1;
        chk("hit_count", {28'b0, hit_count}, 32'(mhit));
        chk("miss_count", {28'b0, miss_count}, 32'(mmiss));
    endtask

    task automatic flush_idle(input logic [31:0] a);
        @(negedge CLK);
        iflush = 1'b1;
        imemREN = 1'b1;
        imemaddr = a;
        #1;
        chk("flush_ihit", {31'b0, ihit}, 0);
        @(negedge CLK);
        iflush = 1'b0;
        imemREN = 1'b0;
        model_clear();
    endtask

    initial begin
        nRST = 1'b0; imemREN = 1'b0; iflush = 1'b0; imemaddr = '0;
        mhit = 0; mmiss = 0;
        model_clear();
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_ihit", {31'b0, ihit}, 0);
        chk("rst_iren", {31'b0, iREN}, 0);
        chk("rst_hits", {28'b0, hit_count}, 0);
        chk("rst_misses", {28'b0, miss_count}, 0);
        @(negedge CLK);
        nRST = 1'b1;
        fetch(32'h40);
        check_counts();
        fetch(32'h44);
        check_counts();
        fetch(32'hC0);
        fetch(32'h40);
        check_counts();
        fetch(32'h100, 1'b1, 32'h200);
        check_counts();
        // Flush while the second word of a fill is outstanding.
        @(negedge CLK);
        imemaddr = 32'h300;
        imemREN = 1'b1;
        #1;
        chk("ff_ihit", {31'b0, ihit}, 0);
        mmiss = sat(mmiss);
        repeat (4) @(negedge CLK);
        #1;
        chk("ff_iaddr", iaddr, 32'h304);
        iflush = 1'b1;
        @(negedge CLK);
        iflush = 1'b0;
        imemREN = 1'b0;
        #1;
        chk("ff_iren", {31'b0, iREN}, 0);
        model_clear();
        check_counts();
        fetch(32'h40);
        fetch(32'h300);
        check_counts();
        flush_idle(32'h40);
        fetch(32'h40);
        fetch(32'h300);
        check_counts();
        // Reset and flush together behave as reset.
        @(negedge CLK);
        nRST = 1'b0;
        iflush = 1'b1;
        @(negedge CLK);
        nRST = 1'b1;
        iflush = 1'b0;
        #1;
        chk("rf_iren", {31'b0, iREN}, 0);
        chk("rf_hits", {28'b0, hit_count}, 0);
        chk("rf_misses", {28'b0, miss_count}, 0);
        mhit = 0; mmiss = 0;
        model_clear();
        fetch(32'h40);
        check_counts();
        repeat (20) fetch(32'h44);
        check_counts();
        chk("hit_sat", {28'b0, hit_count}, 32'hF);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) flush_idle(32'($urandom_range(0, 255)) << 2);
            else fetch(32'($urandom_range(0, 255)) << 2);
            check_counts();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
